// File: rtl/axil_periph_demux.sv
// AXI4-Lite 1-to-N peripheral demultiplexer with address decode, decode-error
// responses and a per-path response watchdog that isolates hung slaves.
module axil_periph_demux #(
  parameter int                               NUM_SLAVES     = 4,
  parameter int                               ADDR_WIDTH     = 32,
  parameter int                               DATA_WIDTH     = 32,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] BASE_ADDRS     = '0,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] ADDR_MASKS     = '0,
  parameter int                               TIMEOUT_CYCLES = 1024,
  parameter logic [31:0]                      ERR_RDATA      = 32'h0000_0000
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  // upstream write channels
  input  logic [ADDR_WIDTH-1:0]          s_awaddr,
  input  logic                           s_awvalid,
  output logic                           s_awready,
  input  logic [DATA_WIDTH-1:0]          s_wdata,
  input  logic [DATA_WIDTH/8-1:0]        s_wstrb,
  input  logic                           s_wvalid,
  output logic                           s_wready,
  output logic [1:0]                     s_bresp,
  output logic                           s_bvalid,
  input  logic                           s_bready,
  // upstream read channels
  input  logic [ADDR_WIDTH-1:0]          s_araddr,
  input  logic                           s_arvalid,
  output logic                           s_arready,
  output logic [DATA_WIDTH-1:0]          s_rdata,
  output logic [1:0]                     s_rresp,
  output logic                           s_rvalid,
  input  logic                           s_rready,
  // downstream write channels
  output logic [ADDR_WIDTH-1:0]          m_awaddr,
  output logic [DATA_WIDTH-1:0]          m_wdata,
  output logic [DATA_WIDTH/8-1:0]        m_wstrb,
  output logic [NUM_SLAVES-1:0]          m_awvalid,
  input  logic [NUM_SLAVES-1:0]          m_awready,
  output logic [NUM_SLAVES-1:0]          m_wvalid,
  input  logic [NUM_SLAVES-1:0]          m_wready,
  input  logic [2*NUM_SLAVES-1:0]        m_bresp,
  input  logic [NUM_SLAVES-1:0]          m_bvalid,
  output logic [NUM_SLAVES-1:0]          m_bready,
  // downstream read channels
  output logic [ADDR_WIDTH-1:0]          m_araddr,
  output logic [NUM_SLAVES-1:0]          m_arvalid,
  input  logic [NUM_SLAVES-1:0]          m_arready,
  input  logic [DATA_WIDTH*NUM_SLAVES-1:0] m_rdata,
  input  logic [2*NUM_SLAVES-1:0]        m_rresp,
  input  logic [NUM_SLAVES-1:0]          m_rvalid,
  output logic [NUM_SLAVES-1:0]          m_rready,
  output logic [NUM_SLAVES-1:0]          hung_o
);

  localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [DATA_WIDTH-1:0] ERR_DATA = DATA_WIDTH'(ERR_RDATA);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] W_IDLE  = 2'd0;
  localparam logic [1:0] W_ISSUE = 2'd1;
  localparam logic [1:0] W_WAITB = 2'd2;
  localparam logic [1:0] W_RESP  = 2'd3;

  localparam logic [1:0] R_IDLE  = 2'd0;
  localparam logic [1:0] R_ISSUE = 2'd1;
  localparam logic [1:0] R_WAITR = 2'd2;
  localparam logic [1:0] R_RESP  = 2'd3;

  // Returns {hit, index}; scanning downward lets the lowest matching index win.
  function automatic logic [SEL_W:0] decode(input logic [ADDR_WIDTH-1:0] addr);
    logic [SEL_W:0] res;
    res = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((addr & ADDR_MASKS[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
          (BASE_ADDRS[i*ADDR_WIDTH +: ADDR_WIDTH] & ADDR_MASKS[i*ADDR_WIDTH +: ADDR_WIDTH]))
        res = {1'b1, SEL_W'(i)};
    end
    return res;
  endfunction

  // ---------------------------------------------------------------- write path
  logic [1:0]       w_state;
  logic             aw_got, w_got, aw_done, wd_done;
  logic [SEL_W-1:0] w_sel;
  logic [CNT_W-1:0] w_cnt;
  logic [SEL_W:0]   w_dec;
  logic             w_to, w_aw_fire, w_w_fire, w_issue_done;
  logic [NUM_SLAVES-1:0] w_hung_set;

  assign w_dec     = decode(m_awaddr);
  assign w_to      = (TIMEOUT_CYCLES != 0) && (w_cnt == TO_LAST);
  assign s_awready = rst_ni && (w_state == W_IDLE) && !aw_got;
  assign s_wready  = rst_ni && (w_state == W_IDLE) && !w_got;
  assign s_bvalid  = (w_state == W_RESP);

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    m_awvalid    = '0;
    m_wvalid     = '0;
    m_bready     = '0;
    w_hung_set   = '0;
    w_aw_fire    = 1'b0;
    w_w_fire     = 1'b0;
    w_issue_done = 1'b0;
    case (w_state)
      W_ISSUE: begin
        m_awvalid[w_sel] = !aw_done;
        m_wvalid[w_sel]  = !wd_done;
        w_aw_fire        = !aw_done && m_awready[w_sel];
        w_w_fire         = !wd_done && m_wready[w_sel];
        w_issue_done     = (aw_done || w_aw_fire) && (wd_done || w_w_fire);
        w_hung_set[w_sel] = w_to;
      end
      W_WAITB: begin
        m_bready[w_sel]   = 1'b1;
        w_hung_set[w_sel] = w_to && !m_bvalid[w_sel];
      end
      default: ;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      w_state  <= W_IDLE;
      aw_got   <= 1'b0;
      w_got    <= 1'b0;
      aw_done  <= 1'b0;
      wd_done  <= 1'b0;
      w_sel    <= '0;
      w_cnt    <= '0;
      s_bresp  <= RESP_OKAY;
      m_awaddr <= '0;
      m_wdata  <= '0;
      m_wstrb  <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (aw_got && w_got) begin
            aw_got  <= 1'b0;
            w_got   <= 1'b0;
            aw_done <= 1'b0;
            wd_done <= 1'b0;
            w_cnt   <= '0;
            w_sel   <= w_dec[SEL_W-1:0];
            if (!w_dec[SEL_W]) begin
              s_bresp <= RESP_DECERR;
              w_state <= W_RESP;
            end else if (hung_o[w_dec[SEL_W-1:0]]) begin
              s_bresp <= RESP_SLVERR;
              w_state <= W_RESP;
            end else begin
              w_state <= W_ISSUE;
            end
          end else begin
            if (s_awvalid && !aw_got) begin
              aw_got   <= 1'b1;
              m_awaddr <= s_awaddr;
            end
            if (s_wvalid && !w_got) begin
              w_got   <= 1'b1;
              m_wdata <= s_wdata;
              m_wstrb <= s_wstrb;
            end
          end
        end
        W_ISSUE: begin
          w_cnt <= w_cnt + 1'b1;
          if (w_aw_fire) aw_done <= 1'b1;
          if (w_w_fire)  wd_done <= 1'b1;
          if (w_to) begin
            s_bresp <= RESP_SLVERR;
            w_state <= W_RESP;
          end else if (w_issue_done) begin
            w_state <= W_WAITB;
          end
        end
        W_WAITB: begin
          w_cnt <= w_cnt + 1'b1;
          if (m_bvalid[w_sel]) begin
            s_bresp <= m_bresp[w_sel*2 +: 2];
            w_state <= W_RESP;
          end else if (w_to) begin
            s_bresp <= RESP_SLVERR;
            w_state <= W_RESP;
          end
        end
        default: begin
          if (s_bready) w_state <= W_IDLE;
        end
      endcase
    end
  end

  // ----------------------------------------------------------------- read path
  logic [1:0]       r_state;
  logic             ar_got;
  logic [SEL_W-1:0] r_sel;
  logic [CNT_W-1:0] r_cnt;
  logic [SEL_W:0]   r_dec;
  logic             r_to;
  logic [NUM_SLAVES-1:0] r_hung_set;

  assign r_dec     = decode(m_araddr);
  assign r_to      = (TIMEOUT_CYCLES != 0) && (r_cnt == TO_LAST);
  assign s_arready = rst_ni && (r_state == R_IDLE) && !ar_got;
  assign s_rvalid  = (r_state == R_RESP);

  always_comb begin
    m_arvalid  = '0;
    m_rready   = '0;
    r_hung_set = '0;
    case (r_state)
      R_ISSUE: begin
        m_arvalid[r_sel]  = 1'b1;
        r_hung_set[r_sel] = r_to;
      end
      R_WAITR: begin
        m_rready[r_sel]   = 1'b1;
        r_hung_set[r_sel] = r_to && !m_rvalid[r_sel];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state  <= R_IDLE;
      ar_got   <= 1'b0;
      r_sel    <= '0;
      r_cnt    <= '0;
      s_rdata  <= '0;
      s_rresp  <= RESP_OKAY;
      m_araddr <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_got) begin
            ar_got <= 1'b0;
            r_cnt  <= '0;
            r_sel  <= r_dec[SEL_W-1:0];
            if (!r_dec[SEL_W]) begin
              s_rdata <= ERR_DATA;
              s_rresp <= RESP_DECERR;
              r_state <= R_RESP;
            end else if (hung_o[r_dec[SEL_W-1:0]]) begin
              s_rdata <= ERR_DATA;
              s_rresp <= RESP_SLVERR;
              r_state <= R_RESP;
            end else begin
              r_state <= R_ISSUE;
            end
          end else if (s_arvalid) begin
            ar_got   <= 1'b1;
            m_araddr <= s_araddr;
          end
        end
        R_ISSUE: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_to) begin
            s_rdata <= ERR_DATA;
            s_rresp <= RESP_SLVERR;
            r_state <= R_RESP;
          end else if (m_arready[r_sel]) begin
            r_state <= R_WAITR;
          end
        end
        R_WAITR: begin
          r_cnt <= r_cnt + 1'b1;
          if (m_rvalid[r_sel]) begin
            s_rdata <= m_rdata[r_sel*DATA_WIDTH +: DATA_WIDTH];
            s_rresp <= m_rresp[r_sel*2 +: 2];
            r_state <= R_RESP;
          end else if (r_to) begin
            s_rdata <= ERR_DATA;
            s_rresp <= RESP_SLVERR;
            r_state <= R_RESP;
          end
        end
        default: begin
          if (s_rready) r_state <= R_IDLE;
        end
      endcase
    end
  end

  // Sticky isolation flags; either path may mark a slave as hung.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) hung_o <= '0;
    else         hung_o <= hung_o | w_hung_set | r_hung_set;
  end

endmodule

// File: tb/tb_axil_periph_demux.sv
// Directed bench for axil_periph_demux: four modelled peripherals, checks latency,
// decode errors, watchdog isolation, concurrency and mid-transaction reset.
module tb_axil_periph_demux;

  localparam int NS = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  // slave 3 overlaps slaves 0..2 so lowest-index priority is exercised
  localparam logic [NS*AW-1:0] BASES =
    {32'h4000_0000, 32'h4000_2000, 32'h4000_1000, 32'h4000_0000};
  localparam logic [NS*AW-1:0] MASKS =
    {32'hF000_0000, 32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F000};

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  logic [AW-1:0] s_awaddr, s_araddr, m_awaddr, m_araddr;
  logic s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic s_arvalid, s_arready, s_rvalid, s_rready;
  logic [DW-1:0] s_wdata, s_rdata, m_wdata;
  logic [3:0] s_wstrb, m_wstrb;
  logic [1:0] s_bresp, s_rresp;
  logic [NS-1:0] m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic [NS-1:0] m_arvalid, m_arready, m_rvalid, m_rready, hung_o;
  logic [2*NS-1:0] m_bresp, m_rresp;
  logic [DW*NS-1:0] m_rdata;

  axil_periph_demux #(
    .NUM_SLAVES(NS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .BASE_ADDRS(BASES), .ADDR_MASKS(MASKS),
    .TIMEOUT_CYCLES(16), .ERR_RDATA(32'h0000_0000)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .m_awaddr(m_awaddr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .hung_o(hung_o)
  );

  // Peripheral model knobs
  logic [NS-1:0] slv_b_en, slv_r_en;
  logic [1:0]    slv_bresp [NS];
  logic [NS-1:0] got_aw, got_w;

  int n_cmp = 0;
  int n_err = 0;
  int awv_cyc [NS];
  int aw_hs_cnt [NS];
  int arv_cyc [NS];
  int onehot_viol = 0;

  // Peripheral model: B one cycle after both AW and W handshakes, R one cycle after AR.
  always @(posedge clk_i) begin
    if (!rst_ni) begin
      m_bvalid <= '0;
      m_rvalid <= '0;
      m_bresp  <= '0;
      m_rresp  <= '0;
      m_rdata  <= '0;
      got_aw   <= '0;
      got_w    <= '0;
    end else begin
      for (int i = 0; i < NS; i++) begin
        if (m_bvalid[i]) begin
          if (m_bready[i]) m_bvalid[i] <= 1'b0;
        end else if ((got_aw[i] || (m_awvalid[i] && m_awready[i])) &&
                     (got_w[i]  || (m_wvalid[i]  && m_wready[i])) && slv_b_en[i]) begin
          m_bvalid[i]       <= 1'b1;
          m_bresp[i*2 +: 2] <= slv_bresp[i];
          got_aw[i]         <= 1'b0;
          got_w[i]          <= 1'b0;
        end else begin
          if (m_awvalid[i] && m_awready[i]) got_aw[i] <= 1'b1;
          if (m_wvalid[i] && m_wready[i])   got_w[i]  <= 1'b1;
        end
        if (m_rvalid[i]) begin
          if (m_rready[i]) m_rvalid[i] <= 1'b0;
        end else if (m_arvalid[i] && m_arready[i] && slv_r_en[i]) begin
          m_rvalid[i]         <= 1'b1;
          m_rresp[i*2 +: 2]   <= 2'b00;
          m_rdata[i*DW +: DW] <= 32'hA000_0000 | (32'(i) << 24) | {16'h0, m_araddr[15:0]};
        end
      end
    end
  end

  // Bookkeeping of downstream activity
  always @(posedge clk_i) begin
    for (int i = 0; i < NS; i++) begin
      if (m_awvalid[i]) awv_cyc[i] <= awv_cyc[i] + 1;
      if (m_awvalid[i] && m_awready[i]) aw_hs_cnt[i] <= aw_hs_cnt[i] + 1;
      if (m_arvalid[i]) arv_cyc[i] <= arv_cyc[i] + 1;
    end
    if ($countones(m_awvalid) > 1 || $countones(m_wvalid) > 1 || $countones(m_bready) > 1 ||
        $countones(m_arvalid) > 1 || $countones(m_rready) > 1)
      onehot_viol <= onehot_viol + 1;
  end

  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (3) @(negedge clk_i);
    n_cmp++; if (s_awready !== 1'b0) begin n_err++; $display("FAIL rst_awready got=%b exp=0", s_awready); end
    n_cmp++; if (s_wready !== 1'b0 || s_arready !== 1'b0) begin n_err++; $display("FAIL rst_wready_arready got=%b%b exp=00", s_wready, s_arready); end
    n_cmp++; if (s_bvalid !== 1'b0 || s_rvalid !== 1'b0) begin n_err++; $display("FAIL rst_resp_valid got=%b%b exp=00", s_bvalid, s_rvalid); end
    n_cmp++; if (hung_o !== 4'b0000) begin n_err++; $display("FAIL rst_hung got=%b exp=0000", hung_o); end
    n_cmp++; if ({m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready} !== 20'h0) begin n_err++; $display("FAIL rst_m_handshakes got=%h exp=0", {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}); end
    rst_ni = 1'b1;
    @(negedge clk_i);
    n_cmp++; if (s_awready !== 1'b1 || s_wready !== 1'b1 || s_arready !== 1'b1) begin n_err++; $display("FAIL rst_release_ready got=%b%b%b exp=111", s_awready, s_wready, s_arready); end
  endtask

  task automatic test_write_basic();
    int aw0;
    aw0 = awv_cyc[2];
    s_awaddr = 32'h4000_2004; s_awvalid = 1'b1;
    s_wdata = 32'hCAFE_F00D; s_wstrb = 4'hF; s_wvalid = 1'b1; s_bready = 1'b1;
    @(negedge clk_i);  // N
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    n_cmp++; if (m_awvalid !== 4'b0000 || s_bvalid !== 1'b0) begin n_err++; $display("FAIL wr_n0 awvalid=%b bvalid=%b exp=0000/0", m_awvalid, s_bvalid); end
    @(negedge clk_i);  // N+1
    n_cmp++; if (m_awvalid !== 4'b0100 || m_wvalid !== 4'b0100) begin n_err++; $display("FAIL wr_issue awvalid=%b wvalid=%b exp=0100/0100", m_awvalid, m_wvalid); end
    n_cmp++; if (m_awaddr !== 32'h4000_2004 || m_wdata !== 32'hCAFE_F00D || m_wstrb !== 4'hF) begin n_err++; $display("FAIL wr_payload got=%h/%h/%h exp=40002004/cafef00d/f", m_awaddr, m_wdata, m_wstrb); end
    @(negedge clk_i);  // N+2
    n_cmp++; if (m_awvalid !== 4'b0000 || m_bready !== 4'b0100 || s_bvalid !== 1'b0) begin n_err++; $display("FAIL wr_waitb awvalid=%b bready=%b bvalid=%b exp=0000/0100/0", m_awvalid, m_bready, s_bvalid); end
    @(negedge clk_i);  // N+3: sampled high at edge N+4
    n_cmp++; if (s_bvalid !== 1'b1 || s_bresp !== 2'b00) begin n_err++; $display("FAIL wr_bresp bvalid=%b bresp=%b exp=1/00", s_bvalid, s_bresp); end
    @(negedge clk_i);
    n_cmp++; if (s_bvalid !== 1'b0 || s_awready !== 1'b1) begin n_err++; $display("FAIL wr_done bvalid=%b awready=%b exp=0/1", s_bvalid, s_awready); end
    n_cmp++; if (awv_cyc[2] - aw0 !== 1) begin n_err++; $display("FAIL wr_awvalid_cycles got=%0d exp=1", awv_cyc[2] - aw0); end
  endtask

  task automatic test_concurrent();
    int bad;
    bad = 0;
    slv_bresp[3] = 2'b01;
    s_bready = 1'b0; s_rready = 1'b1;
    s_araddr = 32'h4000_0010; s_arvalid = 1'b1;
    s_awaddr = 32'h4800_0000; s_awvalid = 1'b1;
    s_wdata = 32'h5555_AAAA; s_wstrb = 4'hF; s_wvalid = 1'b1;
    @(negedge clk_i);  // N
    s_arvalid = 1'b0; s_awvalid = 1'b0; s_wvalid = 1'b0;
    @(negedge clk_i);  // N+1
    n_cmp++; if (m_arvalid !== 4'b0001 || m_awvalid !== 4'b1000) begin n_err++; $display("FAIL cc_issue arvalid=%b awvalid=%b exp=0001/1000", m_arvalid, m_awvalid); end
    repeat (2) @(negedge clk_i);  // N+3
    n_cmp++; if (s_rvalid !== 1'b1 || s_rdata !== 32'hA000_0010 || s_rresp !== 2'b00) begin n_err++; $display("FAIL cc_read got=%b/%h/%b exp=1/a0000010/00", s_rvalid, s_rdata, s_rresp); end
    @(negedge clk_i);  // N+4
    n_cmp++; if (s_rvalid !== 1'b0) begin n_err++; $display("FAIL cc_read_done got=%b exp=0", s_rvalid); end
    for (int k = 0; k < 10; k++) begin
      if (s_bvalid !== 1'b1 || s_bresp !== 2'b01) bad++;
      @(negedge clk_i);
    end
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL cc_b_hold unstable_cycles=%0d exp=0", bad); end
    s_bready = 1'b1;
    @(negedge clk_i);
    n_cmp++; if (s_bvalid !== 1'b0) begin n_err++; $display("FAIL cc_b_done got=%b exp=0", s_bvalid); end
    s_rready = 1'b0;
    slv_bresp[3] = 2'b00;
  endtask

  task automatic test_decode_miss();
    int ar0, aw0;
    ar0 = arv_cyc[0] + arv_cyc[1] + arv_cyc[2] + arv_cyc[3];
    aw0 = awv_cyc[0] + awv_cyc[1] + awv_cyc[2] + awv_cyc[3];
    s_araddr = 32'h5000_0000; s_arvalid = 1'b1; s_rready = 1'b0;
    @(negedge clk_i);  // N
    s_arvalid = 1'b0;
    n_cmp++; if (s_rvalid !== 1'b0) begin n_err++; $display("FAIL miss_r_early got=%b exp=0", s_rvalid); end
    @(negedge clk_i);  // N+1: sampled high at edge N+2
    n_cmp++; if (s_rvalid !== 1'b1 || s_rresp !== 2'b11 || s_rdata !== 32'h0) begin n_err++; $display("FAIL miss_r_resp got=%b/%b/%h exp=1/11/00000000", s_rvalid, s_rresp, s_rdata); end
    @(negedge clk_i);
    n_cmp++; if (s_rvalid !== 1'b1) begin n_err++; $display("FAIL miss_r_hold got=%b exp=1", s_rvalid); end
    s_rready = 1'b1;
    @(negedge clk_i);
    s_rready = 1'b0;
    n_cmp++; if (arv_cyc[0] + arv_cyc[1] + arv_cyc[2] + arv_cyc[3] !== ar0) begin n_err++; $display("FAIL miss_r_arvalid cycles=%0d exp=%0d", arv_cyc[0] + arv_cyc[1] + arv_cyc[2] + arv_cyc[3], ar0); end
    s_awaddr = 32'h0000_0000; s_awvalid = 1'b1;
    s_wdata = 32'h1111_1111; s_wvalid = 1'b1; s_bready = 1'b0;
    @(negedge clk_i);  // N
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    @(negedge clk_i);  // N+1
    n_cmp++; if (s_bvalid !== 1'b1 || s_bresp !== 2'b11) begin n_err++; $display("FAIL miss_w_resp got=%b/%b exp=1/11", s_bvalid, s_bresp); end
    s_bready = 1'b1;
    @(negedge clk_i);
    n_cmp++; if (awv_cyc[0] + awv_cyc[1] + awv_cyc[2] + awv_cyc[3] !== aw0) begin n_err++; $display("FAIL miss_w_awvalid cycles=%0d exp=%0d", awv_cyc[0] + awv_cyc[1] + awv_cyc[2] + awv_cyc[3], aw0); end
  endtask

  task automatic test_w_before_aw();
    int hs0, lat, leak;
    hs0 = aw_hs_cnt[0];
    leak = 0;
    s_bready = 1'b1;
    s_wdata = 32'h1234_5678; s_wstrb = 4'b0011; s_wvalid = 1'b1;
    n_cmp++; if (s_wready !== 1'b1) begin n_err++; $display("FAIL wfirst_wready got=%b exp=1", s_wready); end
    @(negedge clk_i);
    s_wvalid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (s_wready !== 1'b0 || m_wvalid !== 4'b0000 || s_awready !== 1'b1) leak++;
      @(negedge clk_i);
    end
    s_awaddr = 32'h4000_0008; s_awvalid = 1'b1;
    @(negedge clk_i);  // M: AW handshake five edges after W
    s_awvalid = 1'b0;
    @(negedge clk_i);  // M+1
    n_cmp++; if (m_awvalid !== 4'b0001 || m_wvalid !== 4'b0001 || m_wdata !== 32'h1234_5678 || m_wstrb !== 4'b0011) begin n_err++; $display("FAIL wfirst_issue got=%b/%b/%h/%b exp=0001/0001/12345678/0011", m_awvalid, m_wvalid, m_wdata, m_wstrb); end
    lat = 1;
    while (s_bvalid !== 1'b1 && lat < 20) begin
      if (s_wready !== 1'b0) leak++;
      @(negedge clk_i);
      lat++;
    end
    n_cmp++; if (lat !== 3 || s_bresp !== 2'b00) begin n_err++; $display("FAIL wfirst_bresp latency=%0d bresp=%b exp=3/00", lat, s_bresp); end
    n_cmp++; if (leak !== 0) begin n_err++; $display("FAIL wfirst_wready_low violations=%0d exp=0", leak); end
    @(negedge clk_i);
    n_cmp++; if (aw_hs_cnt[0] - hs0 !== 1 || s_wready !== 1'b1) begin n_err++; $display("FAIL wfirst_single hs=%0d wready=%b exp=1/1", aw_hs_cnt[0] - hs0, s_wready); end
  endtask

  task automatic test_timeout();
    int aw1;
    slv_r_en[1] = 1'b0;
    s_araddr = 32'h4000_1010; s_arvalid = 1'b1; s_rready = 1'b0;
    @(negedge clk_i);  // N; R_ISSUE entered at N+1, timeout at N+17
    s_arvalid = 1'b0;
    repeat (16) @(negedge clk_i);
    n_cmp++; if (s_rvalid !== 1'b0 || m_rready !== 4'b0010 || hung_o !== 4'b0000) begin n_err++; $display("FAIL to_before got=%b/%b/%b exp=0/0010/0000", s_rvalid, m_rready, hung_o); end
    @(negedge clk_i);
    n_cmp++; if (s_rvalid !== 1'b1 || s_rresp !== 2'b10 || s_rdata !== 32'h0) begin n_err++; $display("FAIL to_resp got=%b/%b/%h exp=1/10/00000000", s_rvalid, s_rresp, s_rdata); end
    n_cmp++; if (hung_o !== 4'b0010 || m_rready !== 4'b0000) begin n_err++; $display("FAIL to_hung hung=%b rready=%b exp=0010/0000", hung_o, m_rready); end
    s_rready = 1'b1;
    @(negedge clk_i);
    s_rready = 1'b0;
    aw1 = awv_cyc[1];
    s_awaddr = 32'h4000_1000; s_awvalid = 1'b1;
    s_wdata = 32'h2222_2222; s_wvalid = 1'b1; s_bready = 1'b0;
    @(negedge clk_i);  // N
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    @(negedge clk_i);  // N+1
    n_cmp++; if (s_bvalid !== 1'b1 || s_bresp !== 2'b10) begin n_err++; $display("FAIL to_hung_write got=%b/%b exp=1/10", s_bvalid, s_bresp); end
    s_bready = 1'b1;
    @(negedge clk_i);
    n_cmp++; if (awv_cyc[1] !== aw1 || hung_o !== 4'b0010) begin n_err++; $display("FAIL to_isolated awvalid_cycles=%0d hung=%b exp=%0d/0010", awv_cyc[1], hung_o, aw1); end
    slv_r_en[1] = 1'b1;
  endtask

  task automatic test_reset_mid();
    int lat;
    slv_b_en[2] = 1'b0;
    s_awaddr = 32'h4000_2000; s_awvalid = 1'b1;
    s_wdata = 32'h0BAD_F00D; s_wstrb = 4'b1100; s_wvalid = 1'b1; s_bready = 1'b1;
    @(negedge clk_i);  // N
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    repeat (2) @(negedge clk_i);  // N+2: W_WAITB
    n_cmp++; if (m_bready !== 4'b0100) begin n_err++; $display("FAIL rmid_waitb bready=%b exp=0100", m_bready); end
    rst_ni = 1'b0;
    @(negedge clk_i);
    n_cmp++; if (hung_o !== 4'b0000 || m_bready !== 4'b0000 || s_bvalid !== 1'b0 || s_awready !== 1'b0) begin n_err++; $display("FAIL rmid_ctrl hung=%b bready=%b bvalid=%b awready=%b exp=0000/0000/0/0", hung_o, m_bready, s_bvalid, s_awready); end
    n_cmp++; if (m_awaddr !== 32'h0 || m_wdata !== 32'h0 || m_wstrb !== 4'h0 || m_araddr !== 32'h0) begin n_err++; $display("FAIL rmid_regs got=%h/%h/%h/%h exp=0/0/0/0", m_awaddr, m_wdata, m_wstrb, m_araddr); end
    rst_ni = 1'b1;
    slv_b_en[2] = 1'b1;
    @(negedge clk_i);
    s_awaddr = 32'h4000_1004; s_awvalid = 1'b1;
    s_wdata = 32'h3333_4444; s_wstrb = 4'hF; s_wvalid = 1'b1;
    @(negedge clk_i);  // N
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    lat = 0;
    while (s_bvalid !== 1'b1 && lat < 20) begin
      @(negedge clk_i);
      lat++;
    end
    n_cmp++; if (lat !== 3 || s_bresp !== 2'b00) begin n_err++; $display("FAIL rmid_fresh latency=%0d bresp=%b exp=3/00", lat, s_bresp); end
    @(negedge clk_i);
  endtask

  initial begin
    s_awaddr = '0; s_awvalid = 1'b0; s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0;
    s_bready = 1'b0; s_araddr = '0; s_arvalid = 1'b0; s_rready = 1'b0;
    m_awready = '1; m_wready = '1; m_arready = '1;
    slv_b_en = '1; slv_r_en = '1;
    for (int i = 0; i < NS; i++) slv_bresp[i] = 2'b00;
    test_reset();
    test_write_basic();
    test_concurrent();
    test_decode_miss();
    test_w_before_aw();
    test_timeout();
    test_reset_mid();
    n_cmp++; if (onehot_viol !== 0) begin n_err++; $display("FAIL onehot violations=%0d exp=0", onehot_viol); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout sim did not finish exp=finish");
    $fatal(1, "bench time limit expired");
  end

endmodule

// File: doc/axil_periph_demux.md
Name: axil_periph_demux

Overview:
Parametrised AXI4-Lite 1-to-N peripheral demultiplexer with per-slave address rules and decode-error generation. It also has a response timeout watchdog with sticky hung-slave isolation. It sits behind the AXI4-to-AXI4-Lite adapter in the peripheral subsystem and fans out to UART, GPIO, timer and other peripherals. Read and write paths are independent FSMs, each with one outstanding transaction.

Parameters:
NUM_SLAVES, 4, number of downstream AXI4-Lite peripherals (1..16)
ADDR_WIDTH, 32, address width
DATA_WIDTH, 32, data width (32 or 64); STRB = DATA_WIDTH/8
BASE_ADDRS, all zero, packed NUM_SLAVES*ADDR_WIDTH; slave i base at [i*ADDR_WIDTH +: ADDR_WIDTH]
ADDR_MASKS, all zero, packed NUM_SLAVES*ADDR_WIDTH; compare mask per slave
TIMEOUT_CYCLES, 1024, cycles from issue to response before SLVERR; 0 disables the watchdog
ERR_RDATA, 32'h0000_0000, read data returned on DECERR/SLVERR (zero-extended to DATA_WIDTH)

Ports:
clk_i  in  1  clock
rst_ni  in  1  synchronous active-low reset
s_awaddr/s_awvalid/s_awready  in/in/out  ADDR_WIDTH/1/1  upstream write address
s_wdata/s_wstrb/s_wvalid/s_wready  in/in/in/out  DATA_WIDTH/STRB/1/1  upstream write data
s_bresp/s_bvalid/s_bready  out/out/in  2/1/1  upstream write response
s_araddr/s_arvalid/s_arready  in/in/out  ADDR_WIDTH/1/1  upstream read address
s_rdata/s_rresp/s_rvalid/s_rready  out/out/out/in  DATA_WIDTH/2/1/1  upstream read data
m_awaddr, m_wdata, m_wstrb  out  ADDR_WIDTH, DATA_WIDTH, STRB  registered, shared by all slaves
m_awvalid/m_awready, m_wvalid/m_wready  out/in  NUM_SLAVES each  per-slave write handshakes
m_bresp  in  2*NUM_SLAVES;  m_bvalid in, m_bready out  NUM_SLAVES each
m_araddr  out  ADDR_WIDTH  registered, shared
m_arvalid out, m_arready in  NUM_SLAVES each
m_rdata  in  DATA_WIDTH*NUM_SLAVES;  m_rresp  in  2*NUM_SLAVES
m_rvalid in, m_rready out  NUM_SLAVES each
hung_o  out  NUM_SLAVES  sticky per-slave timeout flag

Behaviour:
- Reset (rst_ni=0 at posedge): all FSMs go to IDLE. All valid and ready outputs are 0. hung_o=0. Registered addr/data/resp are 0. Timeout counters are 0. Reset mid-transaction abandons the transaction with no response.
- Decode: slave i matches when (addr & MASK_i) == (BASE_i & MASK_i). Lowest index wins on overlap. No match means a decode miss.
- Write FSM states: W_IDLE, W_ISSUE, W_WAITB, W_RESP.
  - W_IDLE: s_awready=1 while AW not yet captured; s_wready=1 while W not yet captured. AW and W are captured independently, in either order or together.
  - Once both are captured, decode in the next cycle:
    - miss -> W_RESP with bresp=DECERR(2'b11).
    - hung_o[sel]=1 -> W_RESP with SLVERR(2'b10).
    - otherwise -> W_ISSUE.
  - W_ISSUE: m_awvalid[sel] and m_wvalid[sel] are asserted and each held until its own handshake. When both are done -> W_WAITB.
  - W_WAITB: m_bready[sel]=1. On m_bvalid[sel], capture m_bresp slice -> W_RESP.
  - W_RESP: s_bvalid=1, held until s_bready, then -> W_IDLE.
- Read FSM states: R_IDLE, R_ISSUE, R_WAITR, R_RESP. Same structure as the write FSM.
  - R_IDLE: s_arready=1 captures the address.
  - Decode miss or hung slave -> R_RESP with s_rdata=ERR_RDATA and rresp DECERR or SLVERR.
  - R_ISSUE: m_arvalid[sel] held until m_arready[sel].
  - R_WAITR: m_rready[sel]=1; capture rdata/rresp.
  - R_RESP: s_rvalid held until s_rready.
- Latency (slave always ready, responds immediately):
  - Write: AW/W handshake at cycle N, slave handshake at N+2, s_bvalid at N+4.
  - Decode miss: s_bvalid at N+2.
  - Read follows the same timings.
- Timeout: a counter resets on entering ISSUE and increments each cycle in ISSUE or WAIT.
  - At TIMEOUT_CYCLES, the FSM drops all m_* valid/ready for that slave, sets hung_o[sel]=1, and goes to RESP with SLVERR (read data = ERR_RDATA).
  - hung_o is cleared only by reset. Late responses from a hung slave are never accepted, because m_bready/m_rready stay 0 for it.
  - The read and write paths each have their own counter and both can set the same hung bit.
- Read and write may target the same or different slaves concurrently, with no mutual ordering.
- Only one selected-slave bit of any m_*valid/m_*ready vector is ever 1.
- All response outputs are registered; there are no combinational paths from s_* inputs to m_* outputs.

Test Plan:
1. NUM_SLAVES=4, BASE[2]=32'h4000_2000, MASK=32'hFFFF_F000. Write 0x4000_2004 data 0xCAFE_F00D strb 0xF, slave 2 always ready with OKAY -> m_awvalid=4'b0100 for exactly 1 cycle, m_wdata=0xCAFE_F00D, s_bvalid at N+4 with bresp=2'b00.
2. Read 0x5000_0000 (no match) -> s_rvalid 2 cycles after the AR handshake, rresp=2'b11, rdata=0x0000_0000, every m_arvalid bit stays 0.
3. W presented 5 cycles before AW -> W is captured immediately, s_wready=0 afterwards until the response completes, and a single slave write is issued after AW arrives.
4. TIMEOUT_CYCLES=16, slave 1 never asserts m_rvalid -> SLVERR 16 cycles after entering R_ISSUE and hung_o=4'b0010. A follow-up write to slave 1 gets SLVERR with no m_awvalid.
5. Read to slave 0 and write to slave 3 launched in the same cycle, with s_bready held 0 for 10 cycles -> the read completes independently, and s_bvalid stays held and stable until s_bready rises.
6. rst_ni=0 while the write FSM is in W_WAITB -> next cycle all outputs are at reset values and hung_o=0. A fresh write afterwards completes normally.
